conv_window_gen: RTL and testbench

Upstream stage of the conv block. Accepts a raster-order pixel stream (one pixel per accepted cycle) and builds SIZE-1 line buffers plus a SIZE x SIZE shift window. Emits a registered SIZE x SIZE window each time a full valid (unpadded) window exists. Output drives conv's inpMatrixI and ena directly.

---
 rtl/conv_pkg.sv | 11 +
 rtl/conv_line_buffer.sv | 24 ++
 rtl/conv_window_gen.sv | 117 +++++++++++
 tb/tb_conv_window_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the conv block (window generator and conv core).
package conv_pkg;
  localparam int SIZE      = 3;
  localparam int WIDTH_BIT = 8;
  localparam int IMG_W     = 8;
  localparam int IMG_H     = 8;

  typedef logic [WIDTH_BIT-1:0] pixel_t;
  typedef pixel_t [0:SIZE-1][0:SIZE-1] window_t;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: a pixel entering now leaves DEPTH enabled shifts later.
module conv_line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             en,
  input  logic [WIDTH-1:0] pix,
  output logic [WIDTH-1:0] delayed
);
  // Contents are always rewritten before being read within a frame, so no reset.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      mem[0] <= pix;
      for (int k = 1; k < DEPTH; k++) begin
        mem[k] <= mem[k-1];
      end
    end
  end

  assign delayed = mem[DEPTH-1];
endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to SIZE x SIZE sliding window; emits only fully in-image windows,
// one cycle after the pixel completing each window is accepted.
module conv_window_gen import conv_pkg::*; #(
  parameter int SIZE      = conv_pkg::SIZE,
  parameter int WIDTH_BIT = conv_pkg::WIDTH_BIT,
  parameter int IMG_W     = conv_pkg::IMG_W,
  parameter int IMG_H     = conv_pkg::IMG_H
) (
  input  logic                                         clock,
  input  logic                                         nreset,
  input  logic                                         pix_valid,
  input  logic                                         pix_sof,
  input  logic [WIDTH_BIT-1:0]                         pix_in,
  output logic                                         win_valid,
  output logic [0:SIZE-1][0:SIZE-1][WIDTH_BIT-1:0]     win_out,
  output logic                                         frame_done,
  output logic                                         busy
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] FIRST_COL = CW'(SIZE - 1);
  localparam logic [RW-1:0] FIRST_ROW = RW'(SIZE - 1);

  state_t state_reg, state_next;
  logic [CW-1:0] col_reg, col_next, cur_col;
  logic [RW-1:0] row_reg, row_next, cur_row;
  logic take, win_hit, last_hit;
  logic [0:SIZE-1][0:SIZE-1][WIDTH_BIT-1:0] win_reg, win_shift;
  // lb_chain[0] is the live pixel; lb_chain[k] is the same column k rows above.
  logic [WIDTH_BIT-1:0] lb_chain [SIZE];

  assign lb_chain[0] = pix_in;

  generate
    for (genvar gi = 0; gi < SIZE - 1; gi++) begin : g_lb
      conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH_BIT)) u_lb (
        .clock  (clock),
        .en     (take),
        .pix    (lb_chain[gi]),
        .delayed(lb_chain[gi+1])
      );
    end

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
      for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
        if (gj == SIZE - 1) begin : g_new
          assign win_shift[gi][gj] = lb_chain[SIZE-1-gi];
        end else begin : g_old
          assign win_shift[gi][gj] = win_reg[gi][gj+1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A sof pixel is always position (0,0), whether it starts or restarts a frame.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    cur_col    = col_reg;
    cur_row    = row_reg;
    take       = 1'b0;
    win_hit    = 1'b0;
    last_hit   = 1'b0;
    if (pix_valid && (pix_sof || state_reg == RUN)) begin
      take = 1'b1;
      if (pix_sof) begin
        cur_col = '0;
        cur_row = '0;
      end
      win_hit  = (cur_row >= FIRST_ROW) && (cur_col >= FIRST_COL);
      last_hit = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
      if (cur_col == LAST_COL) begin
        col_next = '0;
        row_next = last_hit ? '0 : cur_row + 1'b1;
      end else begin
        col_next = cur_col + 1'b1;
        row_next = cur_row;
      end
      state_next = last_hit ? IDLE : RUN;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      col_reg    <= '0;
      row_reg    <= '0;
      win_reg    <= '0;
      win_out    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col_reg    <= col_next;
      row_reg    <= row_next;
      win_valid  <= take && win_hit;
      frame_done <= take && last_hit;
      if (take) begin
        win_reg <= win_shift;
      end
      if (take && win_hit) begin
        win_out <= win_shift;
      end
    end
  end

  assign busy = (state_reg == RUN);
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed frames into conv_window_gen; a negedge monitor checks each window against a queue
// of windows computed from the known test image.
module tb_conv_window_gen;
  localparam int SIZE = 3;
  localparam int WB   = 8;
  localparam int IW   = 8;
  localparam int IH   = 8;

  typedef logic [0:SIZE-1][0:SIZE-1][WB-1:0] win_t;
  typedef struct {
    win_t w;
    bit   done;
  } exp_t;

  logic          clock;
  logic          nreset;
  logic          pix_valid;
  logic          pix_sof;
  logic [WB-1:0] pix_in;
  logic          win_valid;
  win_t          win_out;
  logic          frame_done;
  logic          busy;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   exp_windows = 0;
  int   exp_dones = 0;
  int   seen_windows = 0;
  int   seen_dones = 0;
  win_t last_win;

  conv_window_gen #(.SIZE(SIZE), .WIDTH_BIT(WB), .IMG_W(IW), .IMG_H(IH)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_in    (pix_in),
    .win_valid (win_valid),
    .win_out   (win_out),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive(input bit v, input bit sof, input logic [WB-1:0] px, input bit chk_busy);
    @(posedge clock);
    #1;
    if (chk_busy) chk("busy_rise", 128'(busy), 128'(1));
    pix_valid = v;
    pix_sof   = sof;
    pix_in    = px;
  endtask

  task automatic push_exp(input int base, input int r, input int c);
    exp_t e;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        e.w[i][j] = WB'(base + (r - SIZE + 1 + i) * IW + (c - SIZE + 1 + j));
      end
    end
    e.done = (r == IH - 1) && (c == IW - 1);
    exp_q.push_back(e);
    exp_windows++;
    if (e.done) exp_dones++;
  endtask

  // Sends p(r,c)=base+r*IW+c; stops just before (stop_r,stop_c) when that lies inside the frame.
  task automatic send_frame(input int base, input bit gaps, input int stop_r, input int stop_c);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r == stop_r && c == stop_c) return;
        drive(1'b1, (r == 0 && c == 0), WB'(base + r * IW + c), (r == 0 && c == 1 && !gaps));
        if (r >= SIZE - 1 && c >= SIZE - 1) push_exp(base, r, c);
        if (gaps) begin
          drive(1'b0, 1'b1, 8'hA5, (r == 0 && c == 0));
          drive(1'b0, 1'b0, 8'h5A, 1'b0);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!nreset) begin
      last_win = '0;
    end else begin
      if (win_valid) begin
        seen_windows++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_window: got %0h want none", win_out);
        end else begin
          e = exp_q.pop_front();
          chk("window", 128'(win_out), 128'(e.w));
          chk("frame_done_with_window", 128'(frame_done), 128'(e.done));
        end
        last_win = win_out;
      end else begin
        chk("win_out_hold", 128'(win_out), 128'(last_win));
        chk("frame_done_idle", 128'(frame_done), 128'(0));
      end
      if (frame_done) seen_dones++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset    = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_in    = '0;
    #2 nreset = 1'b0;
    #1;
    chk("reset_win_valid", 128'(win_valid), 128'(0));
    chk("reset_win_out", 128'(win_out), 128'(0));
    chk("reset_frame_done", 128'(frame_done), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    #24 nreset = 1'b1;

    // Continuous full frame.
    send_frame(0, 1'b0, -1, -1);
    idle(3);
    chk("busy_after_frame", 128'(busy), 128'(0));

    // Same frame with two idle cycles after every pixel.
    send_frame(0, 1'b1, -1, -1);
    idle(3);

    // Pixels without sof while idle are dropped.
    drive(1'b1, 1'b0, 8'd200, 1'b0);
    drive(1'b1, 1'b0, 8'd201, 1'b0);
    drive(1'b1, 1'b0, 8'd202, 1'b0);
    drive(1'b1, 1'b0, 8'd203, 1'b0);
    idle(1);
    chk("busy_ignores_no_sof", 128'(busy), 128'(0));
    send_frame(0, 1'b0, -1, -1);
    idle(3);

    // Restart with sof at (4,3), then a full new frame.
    send_frame(0, 1'b0, 4, 3);
    send_frame(0, 1'b0, -1, -1);
    idle(3);

    // Asynchronous reset mid-frame, between clock edges.
    send_frame(0, 1'b0, 3, 5);
    idle(1);
    @(negedge clock);
    #2 nreset = 1'b0;
    #1;
    chk("async_win_valid", 128'(win_valid), 128'(0));
    chk("async_frame_done", 128'(frame_done), 128'(0));
    chk("async_busy", 128'(busy), 128'(0));
    chk("async_win_out", 128'(win_out), 128'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 nreset = 1'b1;
    send_frame(0, 1'b0, -1, -1);
    idle(3);

    // Back-to-back frames, no bubble.
    send_frame(0, 1'b0, -1, -1);
    send_frame(100, 1'b0, -1, -1);
    idle(4);

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    chk("window_count", 128'(seen_windows), 128'(exp_windows));
    chk("frame_done_count", 128'(seen_dones), 128'(exp_dones));
    chk("busy_end", 128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
